// File: rtl/ofm_requant_drain.sv
// Output stage for the PE array: captures column-sum vectors into a small FIFO,
// requantizes each valid lane to int8 and drains it one byte per handshake.
module ofm_requant_drain #(
   parameter int COL       = 8,
   parameter int OFM_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [COL-1:0]              sum_valid,
   input  logic signed [OFM_WIDTH-1:0] sum [COL],
   input  logic [4:0]                  cfg_shift,
   input  logic                        cfg_relu,
   output logic                        ofm_valid,
   input  logic                        ofm_ready,
   output logic [7:0]                  ofm_data,
   output logic [$clog2(COL)-1:0]      ofm_lane,
   output logic                        ofm_last,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic                        overflow
);

   localparam int LW = $clog2(COL);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic signed [OFM_WIDTH:0] SAT_MAX = {{(OFM_WIDTH-7){1'b0}}, 8'h7F};
   localparam logic signed [OFM_WIDTH:0] SAT_MIN = {{(OFM_WIDTH-7){1'b1}}, 8'h80};

   // One extra bit of headroom keeps the rounding add from wrapping.
   function automatic logic [7:0] requant(input logic signed [OFM_WIDTH-1:0] x,
                                          input logic [4:0] s, input logic relu);
      logic signed [OFM_WIDTH:0] xe;
      logic signed [OFM_WIDTH:0] rnd;
      logic signed [OFM_WIDTH:0] y;
      logic signed [OFM_WIDTH:0] yr;
      logic [7:0]                r;
      xe = {x[OFM_WIDTH-1], x};
      if (s == 5'd0) begin
         rnd = '0;
         y   = xe;
      end else begin
         rnd = {{OFM_WIDTH{1'b0}}, 1'b1} << (s - 5'd1);
         y   = (xe + rnd) >>> s;
      end
      if (relu && y[OFM_WIDTH]) yr = '0;
      else                      yr = y;
      if (yr > SAT_MAX)      r = 8'h7F;
      else if (yr < SAT_MIN) r = 8'h80;
      else                   r = yr[7:0];
      return r;
   endfunction

   function automatic logic [LW-1:0] lowest_set(input logic [COL-1:0] m);
      logic [LW-1:0] idx;
      idx = '0;
      for (int j = COL - 1; j >= 0; j--) begin
         if (m[j]) idx = LW'(j);
      end
      return idx;
   endfunction

   logic [COL-1:0]              mask_mem_q  [DEPTH];
   logic signed [OFM_WIDTH-1:0] sum_mem_q   [DEPTH][COL];
   logic [4:0]                  shift_mem_q [DEPTH];
   logic                        relu_mem_q  [DEPTH];

   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d, count_post;
   logic           overflow_q, overflow_d;
   logic [COL-1:0] rem_mask_q, rem_mask_d, rem_after;
   logic           ofm_valid_q, ofm_valid_d, ofm_last_q, ofm_last_d;
   logic [7:0]     ofm_data_q, ofm_data_d;
   logic [LW-1:0]  ofm_lane_q, ofm_lane_d;

   logic                        hs, pop, push, drop, head_from_in;
   logic signed [OFM_WIDTH-1:0] head_x;
   logic [4:0]                  head_s;
   logic                        head_r;

   // Next-state: FIFO bookkeeping plus the byte the output registers present next cycle.
   always_comb begin
      hs           = ofm_valid_q & ofm_ready;
      pop          = hs & ofm_last_q;
      count_post   = count_q - CW'(pop);
      push         = (|sum_valid) && (count_post != CW'(DEPTH));
      drop         = (|sum_valid) && (count_post == CW'(DEPTH));
      count_d      = count_post + CW'(push);
      wr_ptr_d     = wr_ptr_q + PW'(push);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      overflow_d   = overflow_q | drop;
      head_from_in = (count_post == '0);

      if (hs) rem_after = rem_mask_q & ~({{(COL-1){1'b0}}, 1'b1} << ofm_lane_q);
      else    rem_after = rem_mask_q;

      // An empty FIFO after this edge means the incoming vector (if any) becomes the head directly.
      if (head_from_in) begin
         if (push) rem_mask_d = sum_valid;
         else      rem_mask_d = '0;
      end else if (pop) begin
         rem_mask_d = mask_mem_q[rd_ptr_d];
      end else begin
         rem_mask_d = rem_after;
      end

      ofm_lane_d  = lowest_set(rem_mask_d);
      ofm_valid_d = |rem_mask_d;
      ofm_last_d  = ofm_valid_d &&
                    ((rem_mask_d & (rem_mask_d - {{(COL-1){1'b0}}, 1'b1})) == '0);

      if (head_from_in) begin
         head_x = sum[ofm_lane_d];
         head_s = cfg_shift;
         head_r = cfg_relu;
      end else begin
         head_x = sum_mem_q[rd_ptr_d][ofm_lane_d];
         head_s = shift_mem_q[rd_ptr_d];
         head_r = relu_mem_q[rd_ptr_d];
      end

      if (ofm_valid_d) ofm_data_d = requant(head_x, head_s, head_r);
      else             ofm_data_d = 8'h00;
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         rem_mask_q  <= '0;
         ofm_valid_q <= 1'b0;
         ofm_data_q  <= 8'h00;
         ofm_lane_q  <= '0;
         ofm_last_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         rem_mask_q  <= rem_mask_d;
         ofm_valid_q <= ofm_valid_d;
         ofm_data_q  <= ofm_data_d;
         ofm_lane_q  <= ofm_lane_d;
         ofm_last_q  <= ofm_last_d;
      end
   end

   // Vector storage; stale contents are harmless because pointers and count are reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mask_mem_q[wr_ptr_q]  <= sum_valid;
         sum_mem_q[wr_ptr_q]   <= sum;
         shift_mem_q[wr_ptr_q] <= cfg_shift;
         relu_mem_q[wr_ptr_q]  <= cfg_relu;
      end
   end

   assign ofm_valid  = ofm_valid_q;
   assign ofm_data   = ofm_data_q;
   assign ofm_lane   = ofm_lane_q;
   assign ofm_last   = ofm_last_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ofm_requant_drain.sv
// Scoreboard bench for ofm_requant_drain: stimulus queues hand-computed bytes,
// a negedge monitor pops and compares every accepted output byte.
module tb_ofm_requant_drain;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        sum_valid;
   logic signed [31:0] sum [8];
   logic [4:0]        cfg_shift;
   logic              cfg_relu;
   logic              ofm_valid;
   logic              ofm_ready;
   logic [7:0]        ofm_data;
   logic [2:0]        ofm_lane;
   logic              ofm_last;
   logic [2:0]        fifo_count;
   logic              overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] lane;
      logic       last;
   } exp_t;
   exp_t exp_q[$];

   logic signed [31:0] v_ramp [8];
   logic signed [31:0] v_odd  [8];
   logic signed [31:0] v_str  [8];
   logic signed [31:0] v_tmp  [8];

   always #5 clk = ~clk;

   ofm_requant_drain #(.COL(8), .OFM_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .sum_valid(sum_valid), .sum(sum),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data),
      .ofm_lane(ofm_lane), .ofm_last(ofm_last),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic ex(input logic [7:0] d, input logic [2:0] l, input logic last);
      exp_t e;
      e.d = d; e.lane = l; e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] m, input logic signed [31:0] v [8],
                       input logic [4:0] s, input logic r);
      sum_valid = m;
      sum       = v;
      cfg_shift = s;
      cfg_relu  = r;
      @(posedge clk); #1;
      sum_valid = 8'h00;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic exp_ramp_s2();
      ex(8'h00, 3'd0, 1'b0); ex(8'h19, 3'd1, 1'b0); ex(8'h32, 3'd2, 1'b0);
      ex(8'h4B, 3'd3, 1'b0); ex(8'h64, 3'd4, 1'b0); ex(8'h7D, 3'd5, 1'b0);
      ex(8'h7F, 3'd6, 1'b0); ex(8'h7F, 3'd7, 1'b1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, 32'(ofm_valid), 32'd0);
      chk({tag, "_data"},  32'(ofm_data),  32'd0);
      chk({tag, "_lane"},  32'(ofm_lane),  32'd0);
      chk({tag, "_last"},  32'(ofm_last),  32'd0);
      chk({tag, "_count"}, 32'(fifo_count), 32'd0);
   endtask

   // Scoreboard monitor: one comparison per accepted byte.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && ofm_valid && ofm_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte: got data=%0h lane=%0d last=%0d, none expected",
                        ofm_data, ofm_lane, ofm_last);
            end else begin
               e = exp_q.pop_front();
               if (ofm_data !== e.d || ofm_lane !== e.lane || ofm_last !== e.last) begin
                  failures++;
                  $display("FAIL byte: got data=%0h lane=%0d last=%0d expected data=%0h lane=%0d last=%0d",
                           ofm_data, ofm_lane, ofm_last, e.d, e.lane, e.last);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      sum_valid = 8'h00;
      ofm_ready = 1'b0;
      cfg_shift = 5'd0;
      cfg_relu  = 1'b0;
      for (int j = 0; j < 8; j++) begin
         sum[j]    = 32'sd0;
         v_ramp[j] = 32'(j * 100);
         v_odd[j]  = 32'(j * 10 + 5);
         v_tmp[j]  = 32'sd0;
      end
      v_str = '{-32'sd7, 32'sd0, 32'sd6, 32'sd0, -32'sd300, 32'sd0, 32'sd1000, 32'sd0};

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      chk("reset_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;

      // Full vector, shift 2: saturates on lanes 6 and 7.
      ofm_ready = 1'b1;
      exp_ramp_s2();
      send(8'hFF, v_ramp, 5'd2, 1'b0);
      chk("latency_valid", 32'(ofm_valid), 32'd1);
      chk("latency_lane",  32'(ofm_lane),  32'd0);
      wait_drain();

      // Stride mask with ReLU, then without, back to back.
      ex(8'h00, 3'd0, 1'b0); ex(8'h03, 3'd2, 1'b0); ex(8'h00, 3'd4, 1'b0); ex(8'h7F, 3'd6, 1'b1);
      ex(8'hFD, 3'd0, 1'b0); ex(8'h03, 3'd2, 1'b0); ex(8'h80, 3'd4, 1'b0); ex(8'h7F, 3'd6, 1'b1);
      send(8'h55, v_str, 5'd1, 1'b1);
      send(8'h55, v_str, 5'd1, 1'b0);
      wait_drain();

      // Backpressure: head byte must hold for 5 stalled cycles.
      ofm_ready = 1'b0;
      for (int j = 0; j < 8; j++) ex(8'(j * 10 + 5), 3'(j), (j == 7));
      send(8'hFF, v_odd, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(ofm_valid), 32'd1);
         chk("stall_data",  32'(ofm_data),  32'h05);
         chk("stall_lane",  32'(ofm_lane),  32'd0);
         chk("stall_last",  32'(ofm_last),  32'd0);
         @(posedge clk); #1;
      end
      ofm_ready = 1'b1;
      wait_drain();

      // Overflow: five pushes into a four-deep FIFO with no drain.
      ofm_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         v_tmp[0] = 32'(10 * k);
         v_tmp[1] = -32'(10 * k);
         if (k <= 4) begin
            ex(8'(10 * k), 3'd0, 1'b0);
            ex(8'(-10 * k), 3'd1, 1'b1);
         end
         send(8'h03, v_tmp, 5'd0, 1'b0);
         if (k == 4) begin
            chk("full_count",    32'(fifo_count), 32'd4);
            chk("full_overflow", 32'(overflow),   32'd0);
         end
      end
      chk("ovf_count", 32'(fifo_count), 32'd4);
      chk("ovf_flag",  32'(overflow),   32'd1);
      ofm_ready = 1'b1;
      wait_drain();
      chk("ovf_drained_count", 32'(fifo_count), 32'd0);
      chk("ovf_sticky",        32'(overflow),   32'd1);

      // Push accepted in the same cycle the full FIFO pops its head.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_clears_overflow", 32'(overflow), 32'd0);
      ofm_ready = 1'b0;
      v_tmp[1] = 32'sd0;
      for (int k = 1; k <= 4; k++) begin
         v_tmp[0] = 32'(k * 3);
         ex(8'(k * 3), 3'd0, 1'b1);
         send(8'h01, v_tmp, 5'd0, 1'b0);
      end
      chk("simul_pre_count", 32'(fifo_count), 32'd4);
      ofm_ready = 1'b1;
      v_tmp[0]  = 32'sd99;
      ex(8'h63, 3'd0, 1'b1);
      send(8'h01, v_tmp, 5'd0, 1'b0);
      chk("simul_count",    32'(fifo_count), 32'd4);
      chk("simul_overflow", 32'(overflow),   32'd0);
      wait_drain();
      chk("simul_end_count",    32'(fifo_count), 32'd0);
      chk("simul_end_overflow", 32'(overflow),   32'd0);

      // Reset while lane 3 is presented; capture in the reset cycle is ignored.
      ofm_ready = 1'b1;
      ex(8'h05, 3'd0, 1'b0); ex(8'h0F, 3'd1, 1'b0); ex(8'h19, 3'd2, 1'b0);
      send(8'hFF, v_odd, 5'd0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("mid_lane", 32'(ofm_lane), 32'd3);
      rst       = 1'b1;
      sum_valid = 8'h01;
      @(posedge clk); #1;
      rst       = 1'b0;
      sum_valid = 8'h00;
      chk_reset_state("midrst");
      chk("midrst_overflow", 32'(overflow), 32'd0);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);
      exp_ramp_s2();
      send(8'hFF, v_ramp, 5'd2, 1'b0);
      chk("fresh_valid", 32'(ofm_valid), 32'd1);
      chk("fresh_lane",  32'(ofm_lane),  32'd0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
